bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Arbitrates and sequences the shared result bus that drives `bus_dat` into the register file and operand paths.
- The bus is wired-OR, so every non-selected source must drive all zeros. This block grants exactly one source per cycle (round-robin) and forces zero on every non-granted source.
- It sits between the functional units (ALU1, ALU2, ALU2 carry, LDST1, GPRF read, immediate) and the bus OR-tree.
- It supports locked multi-cycle transfers with a bounded hold time.

Parameters:
- N_SRC, 6, number of bus sources; index 0 = imm, 1 = alu1, 2 = alu2, 3 = alu2_cry, 4 = ldst1, 5 = gprf.
- DAT_W, `DAT_W (from define.v), bus data width.
- MAX_HOLD, 8, maximum consecutive cycles a locked grant may be held; range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req  input  N_SRC  per-source bus request; held until granted
- lock  input  N_SRC  per-source request to keep the grant next cycle
- src_dat  input  N_SRC*DAT_W  source data, packed; source i occupies [i*DAT_W +: DAT_W]
- gnt  output  N_SRC  registered one-hot grant; all-zero when idle
- bus_vld  output  1  bus carries valid data this cycle (equals |gnt)
- bus_src  output  3  binary index of granted source; 0 when idle
- bus_dat  output  DAT_W  OR of (src_dat[i] masked by gnt[i]); combinational from gnt and src_dat
- hold_ovf  output  1  one-cycle pulse when a locked grant is force-released at MAX_HOLD

Behaviour:
- Reset: gnt=0, bus_vld=0, bus_src=0, hold_ovf=0, rr_ptr=0, hold_cnt=0, FSM=IDLE. bus_dat=0 while gnt=0.
- FSM has two states, IDLE and BUSY.
- Arbitration latency:
  - A req sampled at edge k produces gnt at edge k+1.
  - Data is transferred in the cycle gnt is high.
  - The source deasserts req in the cycle it sees gnt, unless it holds lock.
- Round-robin:
  - Search starts at rr_ptr and wraps modulo N_SRC.
  - The first req bit found wins.
  - On each new grant, rr_ptr = winner+1, wrapping to 0 after N_SRC-1.
- IDLE:
  - If any req: go to BUSY, gnt=onehot(winner), hold_cnt=1.
  - Otherwise stay IDLE with gnt=0.
- BUSY, granted source g:
  - If lock[g]=1 and hold_cnt<MAX_HOLD: keep gnt and increment hold_cnt. req of other sources is ignored.
  - If lock[g]=1 and hold_cnt==MAX_HOLD: pulse hold_ovf for one cycle and re-arbitrate. g is excluded from this arbitration round.
  - If lock[g]=0: re-arbitrate across all req. This includes g; because rr_ptr has advanced past g, g ranks last.
  - If re-arbitration finds a winner: grant it (back-to-back, no bubble) and set hold_cnt=1.
  - If it finds none: go to IDLE and set gnt=0.
- lock on a non-granted source has no effect.
- Simultaneous requests: exactly one grant; `$onehot0(gnt)` holds in every cycle.
- rst asserted mid-transfer: gnt drops to 0 at the next edge. Nothing is held over.
- bus_dat is a pure AND-OR of gnt and src_dat. No register on the data path.
- bus_src is the encoded value of gnt, registered together with gnt.

Optional Feature:
- Macro: BUS_COLLISION_CHK_EN.
- When defined:
  - Adds output `bus_err` (1 bit, sticky, cleared only by rst).
  - bus_err sets when any non-granted source presents nonzero src_dat while its req=0. This flags a unit violating the zero-drive rule on the raw OR-bus.
  - Adds output `bus_err_src` (3 bits): index of the lowest offending source, latched on the first error.
  - bus_err and bus_err_src reset to 0.
- When undefined: neither port exists and no check logic is generated.

Decomposition:
- Shared package `bus_pkg`:
  - N_SRC
  - source index constants (SRC_IMM=0 … SRC_GPRF=5)
  - FSM state encoding (IDLE=1'b0, BUSY=1'b1)
  - width of bus_src
- DAT_W remains from define.v.
- One sub-module: `rr_pick`. Combinational round-robin priority picker.
  - Inputs: req, rr_ptr, exclude mask.
  - Outputs: onehot, index, found.

Test Plan:
- Reset, then req=6'b000010 → gnt=6'b000010 one cycle later; bus_src=1; bus_dat=src_dat[1]; gnt=0 the cycle after req drops.
- req=6'b111111 held for 6 cycles, lock=0 → grants 0,1,2,3,4,5 in order, no idle cycle between them; rr_ptr wraps to 0.
- Source 4 granted with lock[4]=1 held continuously, MAX_HOLD=8, req[2]=1 → gnt[4] for 8 cycles, hold_ovf pulses once, then gnt=6'b000100.
- Source 3 granted with src_dat[1]=32'hFFFF_FFFF and src_dat[3]=32'h0000_1234 → bus_dat=32'h0000_1234.
- rst asserted while BUSY with lock held → next cycle gnt=0, bus_vld=0, hold_cnt=0; after release, req=6'b100000 → gnt=6'b100000.
- With BUS_COLLISION_CHK_EN defined: src_dat[2]=nonzero, req[2]=0, source 1 granted → bus_err=1, bus_err_src=2; both persist until rst.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants for the result-bus arbiter: source indices, FSM encoding, widths.
// DAT_W comes from define.v; a 32-bit fallback keeps the package self-contained.
`ifndef DAT_W
`define DAT_W 32
`endif

package bus_pkg;
    localparam int N_SRC = 6;
    localparam int DAT_W = `DAT_W;
    localparam int SRC_W = 3;

    localparam logic [SRC_W-1:0] SRC_IMM      = 3'd0;
    localparam logic [SRC_W-1:0] SRC_ALU1     = 3'd1;
    localparam logic [SRC_W-1:0] SRC_ALU2     = 3'd2;
    localparam logic [SRC_W-1:0] SRC_ALU2_CRY = 3'd3;
    localparam logic [SRC_W-1:0] SRC_LDST1    = 3'd4;
    localparam logic [SRC_W-1:0] SRC_GPRF     = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Round-robin pointer successor, wrapping after the last source.
    function automatic logic [SRC_W-1:0] ptr_next(input logic [SRC_W-1:0] idx);
        return (idx == SRC_GPRF) ? SRC_IMM : idx + 3'd1;
    endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// Result-bus handshake bundle: source-side requests/data and arbiter-side grant/bus.
// The BUS_COLLISION_CHK_EN macro adds the sticky collision-error signals.
interface bus_arbiter_if;
    import bus_pkg::*;

    logic [N_SRC-1:0]       req;
    logic [N_SRC-1:0]       lock;
    logic [N_SRC*DAT_W-1:0] src_dat;
    logic [N_SRC-1:0]       gnt;
    logic                   bus_vld;
    logic [SRC_W-1:0]       bus_src;
    logic [DAT_W-1:0]       bus_dat;
    logic                   hold_ovf;
`ifdef BUS_COLLISION_CHK_EN
    logic                   bus_err;
    logic [SRC_W-1:0]       bus_err_src;

    modport master (output req, lock, src_dat,
                    input  gnt, bus_vld, bus_src, bus_dat, hold_ovf, bus_err, bus_err_src);
    modport slave  (input  req, lock, src_dat,
                    output gnt, bus_vld, bus_src, bus_dat, hold_ovf, bus_err, bus_err_src);
`else
    modport master (output req, lock, src_dat,
                    input  gnt, bus_vld, bus_src, bus_dat, hold_ovf);
    modport slave  (input  req, lock, src_dat,
                    output gnt, bus_vld, bus_src, bus_dat, hold_ovf);
`endif
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after rr_ptr (mod N_SRC),
// ignoring sources set in excl.
module rr_pick
    import bus_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] rr_ptr,
    input  logic [N_SRC-1:0] excl,
    output logic [N_SRC-1:0] onehot,
    output logic [SRC_W-1:0] index,
    output logic             found
);
    logic [N_SRC-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] pos;
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(N_SRC))
                sum = sum - (SRC_W+1)'(N_SRC);
            pos = sum[SRC_W-1:0];
            if (!found && cand[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                index       = pos;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the wired-OR result bus with bounded locked transfers.
// Define BUS_COLLISION_CHK_EN to add the sticky zero-drive violation detector.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    logic [0:0]       state;
    logic [SRC_W-1:0] rr_ptr;
    logic [7:0]       hold_cnt;
    logic [N_SRC-1:0] gnt_r;
    logic [SRC_W-1:0] src_r;
    logic             ovf_r;

    logic             g_lock, keep, force_rel;
    logic [N_SRC-1:0] excl, pick_oh;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_found;

    assign g_lock    = (state == ST_BUSY) && bus.lock[src_r];
    assign keep      = g_lock && (hold_cnt < 8'(MAX_HOLD));
    assign force_rel = g_lock && !keep;
    // A force-released owner sits out one round so the waiting sources get the bus.
    assign excl      = force_rel ? gnt_r : '0;

    rr_pick u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .excl   (excl),
        .onehot (pick_oh),
        .index  (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gnt_r    <= '0;
            src_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            ovf_r <= force_rel;
            if (keep) begin
                hold_cnt <= hold_cnt + 8'd1;
            end else if (pick_found) begin
                state    <= ST_BUSY;
                gnt_r    <= pick_oh;
                src_r    <= pick_idx;
                rr_ptr   <= ptr_next(pick_idx);
                hold_cnt <= 8'd1;
            end else begin
                state    <= ST_IDLE;
                gnt_r    <= '0;
                src_r    <= '0;
                hold_cnt <= '0;
            end
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.bus_vld  = |gnt_r;
    assign bus.bus_src  = src_r;
    assign bus.hold_ovf = ovf_r;

    // Unregistered AND-OR data path so the granted value reaches the bus in the grant cycle.
    always_comb begin
        bus.bus_dat = '0;
        for (int i = 0; i < N_SRC; i++)
            bus.bus_dat = bus.bus_dat | (bus.src_dat[i*DAT_W +: DAT_W] & {DAT_W{gnt_r[i]}});
    end

`ifdef BUS_COLLISION_CHK_EN
    logic             viol_any;
    logic [SRC_W-1:0] viol_idx;
    logic             err_r;
    logic [SRC_W-1:0] err_src_r;

    always_comb begin
        viol_any = 1'b0;
        viol_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!viol_any && !gnt_r[i] && !bus.req[i] && (bus.src_dat[i*DAT_W +: DAT_W] != '0)) begin
                viol_any = 1'b1;
                viol_idx = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r     <= 1'b0;
            err_src_r <= '0;
        end else if (!err_r && viol_any) begin
            err_r     <= 1'b1;
            err_src_r <= viol_idx;
        end
    end

    assign bus.bus_err     = err_r;
    assign bus.bus_err_src = err_src_r;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner sequences,
// and randomized traffic against a behavioural round-robin model.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_if bus();

    bus_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: owner index (-1 idle), next search start, hold length.
    int m_g = -1;
    int m_ptr = 0;
    int m_hold = 0;
    bit m_ovf = 1'b0;

    typedef struct {
        logic [5:0] req;
        logic [5:0] lock;
        logic [5:0] gnt;
        logic [2:0] src;
        logic       ovf;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_dat(input int i, input logic [DAT_W-1:0] v);
        bus.src_dat[i*DAT_W +: DAT_W] = v;
    endtask

    function automatic logic [DAT_W-1:0] dat_of(input int i);
        return bus.src_dat[i*DAT_W +: DAT_W];
    endfunction

    task automatic model_step(input logic [5:0] r, input logic [5:0] l, input logic rs);
        int excl_src;
        int winner;
        bit arb;
        if (rs) begin
            m_g = -1; m_ptr = 0; m_hold = 0; m_ovf = 1'b0;
            return;
        end
        excl_src = -1;
        arb = 1'b0;
        m_ovf = 1'b0;
        if (m_g < 0) arb = 1'b1;
        else if (l[m_g] && m_hold < MAXH) m_hold++;
        else begin
            arb = 1'b1;
            if (l[m_g]) begin excl_src = m_g; m_ovf = 1'b1; end
        end
        if (arb) begin
            winner = -1;
            for (int k = 0; k < N_SRC; k++) begin
                int c;
                c = (m_ptr + k) % N_SRC;
                if (winner < 0 && r[c] && c != excl_src) winner = c;
            end
            if (winner >= 0) begin
                m_g = winner; m_ptr = (winner + 1) % N_SRC; m_hold = 1;
            end else begin
                m_g = -1; m_hold = 0;
            end
        end
    endtask

    task automatic cyc(input logic [5:0] r, input logic [5:0] l);
        bus.req = r;
        bus.lock = l;
        @(posedge clk);
        #1;
        model_step(r, l, rst);
    endtask

    task automatic check_model(input string tag);
        logic [5:0] eg;
        eg = (m_g < 0) ? 6'd0 : 6'(1 << m_g);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(eg));
        chk({tag, "_src"}, 64'(bus.bus_src), (m_g < 0) ? 64'd0 : 64'(m_g));
        chk({tag, "_vld"}, 64'(bus.bus_vld), 64'(m_g >= 0));
        chk({tag, "_ovf"}, 64'(bus.hold_ovf), 64'(m_ovf));
        chk({tag, "_dat"}, 64'(bus.bus_dat), (m_g < 0) ? 64'd0 : 64'(dat_of(m_g)));
        chk({tag, "_onehot0"}, 64'($onehot0(bus.gnt)), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 6; i++)
            tbl[i] = '{req: 6'h3f, lock: 6'h00, gnt: 6'(1 << i), src: 3'(i), ovf: 1'b0};
        tbl[6] = '{req: 6'h00, lock: 6'h00, gnt: 6'h00, src: 3'd0, ovf: 1'b0};
        tbl[7] = '{req: 6'h02, lock: 6'h00, gnt: 6'h02, src: 3'd1, ovf: 1'b0};
        tbl[8] = '{req: 6'h00, lock: 6'h00, gnt: 6'h00, src: 3'd0, ovf: 1'b0};

        rst = 1'b1;
        bus.req = '0;
        bus.lock = '0;
        bus.src_dat = '0;
        for (int i = 0; i < N_SRC; i++) set_dat(i, DAT_W'(32'hA000_0000 | (i * 32'h111 + 32'h10)));
        repeat (2) @(posedge clk);
        #1;
        model_step(6'd0, 6'd0, 1'b1);
        chk("reset_gnt", 64'(bus.gnt), 64'd0);
        chk("reset_vld", 64'(bus.bus_vld), 64'd0);
        chk("reset_src", 64'(bus.bus_src), 64'd0);
        chk("reset_ovf", 64'(bus.hold_ovf), 64'd0);
        chk("reset_dat", 64'(bus.bus_dat), 64'd0);
        rst = 1'b0;

        // Directed table: full round-robin sweep, then single request.
        for (int v = 0; v < 9; v++) begin
            cyc(tbl[v].req, tbl[v].lock);
            chk($sformatf("tbl%0d_gnt", v), 64'(bus.gnt), 64'(tbl[v].gnt));
            chk($sformatf("tbl%0d_src", v), 64'(bus.bus_src), 64'(tbl[v].src));
            chk($sformatf("tbl%0d_vld", v), 64'(bus.bus_vld), 64'(tbl[v].gnt != 0));
            chk($sformatf("tbl%0d_ovf", v), 64'(bus.hold_ovf), 64'(tbl[v].ovf));
            chk($sformatf("tbl%0d_dat", v), 64'(bus.bus_dat),
                (tbl[v].gnt != 0) ? 64'(dat_of(int'(tbl[v].src))) : 64'd0);
        end

        // Locked hold on source 4 with source 2 waiting: forced release at MAX_HOLD.
        cyc(6'b010000, 6'b010000);
        chk("lock_first_gnt", 64'(bus.gnt), 64'h10);
        for (int c = 0; c < MAXH - 1; c++) begin
            cyc(6'b010100, 6'b010000);
            chk($sformatf("lock_hold%0d_gnt", c), 64'(bus.gnt), 64'h10);
            chk($sformatf("lock_hold%0d_ovf", c), 64'(bus.hold_ovf), 64'd0);
        end
        cyc(6'b010100, 6'b010000);
        chk("lock_rel_gnt", 64'(bus.gnt), 64'h04);
        chk("lock_rel_src", 64'(bus.bus_src), 64'd2);
        chk("lock_rel_ovf", 64'(bus.hold_ovf), 64'd1);
        cyc(6'b000000, 6'b000000);
        chk("lock_after_gnt", 64'(bus.gnt), 64'd0);
        chk("lock_after_ovf", 64'(bus.hold_ovf), 64'd0);

        // Masking: a non-granted all-ones source must not leak onto the bus.
        set_dat(1, DAT_W'(32'hFFFF_FFFF));
        set_dat(3, DAT_W'(32'h0000_1234));
        cyc(6'b001000, 6'b000000);
        chk("mask_gnt", 64'(bus.gnt), 64'h08);
        chk("mask_dat", 64'(bus.bus_dat), 64'h1234);
        cyc(6'b000000, 6'b000000);

        // Reset while a locked transfer is in progress.
        cyc(6'b000001, 6'b000001);
        chk("rstmid_gnt_before", 64'(bus.gnt), 64'h01);
        cyc(6'b000001, 6'b000001);
        rst = 1'b1;
        cyc(6'b000001, 6'b000001);
        chk("rstmid_gnt", 64'(bus.gnt), 64'd0);
        chk("rstmid_vld", 64'(bus.bus_vld), 64'd0);
        chk("rstmid_hold", 64'(dut.hold_cnt), 64'd0);
        rst = 1'b0;
        cyc(6'b100000, 6'b000000);
        chk("rstmid_after_gnt", 64'(bus.gnt), 64'h20);
        chk("rstmid_after_src", 64'(bus.bus_src), 64'd5);
        cyc(6'b000000, 6'b000000);

`ifdef BUS_COLLISION_CHK_EN
        rst = 1'b1;
        bus.src_dat = '0;
        cyc(6'b000000, 6'b000000);
        rst = 1'b0;
        cyc(6'b000000, 6'b000000);
        chk("coll_clean_err", 64'(bus.bus_err), 64'd0);
        cyc(6'b000010, 6'b000000);
        set_dat(2, DAT_W'(32'h0000_0055));
        cyc(6'b000000, 6'b000000);
        chk("coll_err", 64'(bus.bus_err), 64'd1);
        chk("coll_err_src", 64'(bus.bus_err_src), 64'd2);
        set_dat(2, '0);
        set_dat(4, DAT_W'(32'h0000_0001));
        repeat (3) cyc(6'b000000, 6'b000000);
        chk("coll_sticky_err", 64'(bus.bus_err), 64'd1);
        chk("coll_sticky_src", 64'(bus.bus_err_src), 64'd2);
        rst = 1'b1;
        cyc(6'b000000, 6'b000000);
        chk("coll_rst_err", 64'(bus.bus_err), 64'd0);
        chk("coll_rst_src", 64'(bus.bus_err_src), 64'd0);
        rst = 1'b0;
`endif

        // Randomized traffic against the model; lock is often held to hit MAX_HOLD.
        rst = 1'b1;
        cyc(6'b000000, 6'b000000);
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [5:0] r;
            logic [5:0] l;
            for (int i = 0; i < N_SRC; i++) set_dat(i, DAT_W'($urandom));
            r = 6'($urandom);
            l = ($urandom_range(0, 3) != 0) ? 6'h3f : 6'($urandom);
            if ($urandom_range(0, 7) == 0) r = 6'd0;
            if (n == 300) rst = 1'b1;
            cyc(r, l);
            rst = 1'b0;
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
